// File: rtl/fibonacci_pkg.sv
// Shared constants for the Fibonacci term generator.
// Term width, index width and sequence seeds.
package fibonacci_pkg;
  localparam int OUT_W = 4;
  localparam int IDX_W = 4;
  localparam logic [OUT_W-1:0] SEED_A = 4'd0;
  localparam logic [OUT_W-1:0] SEED_B = 4'd1;
endpackage

// File: rtl/fib_term_counter.sv
// Modulo-N term index with a registered wrap flag.
// last is high exactly while idx sits at N-1.
module fib_term_counter
  import fibonacci_pkg::*;
#(
  parameter int N = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] PRE_IDX = IDX_W'(N - 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      last <= 1'b0;
    end else if (last) begin
      idx  <= '0;
      last <= 1'b0;
    end else begin
      idx  <= idx + 1'b1;
      last <= (idx == PRE_IDX);
    end
  end

endmodule

// File: rtl/fibonacci.sv
// Fibonacci terms modulo 16, restarting every N terms.
// a is the current term, b the next; both reseed on wrap.
module fibonacci
  import fibonacci_pkg::*;
#(
  parameter int N = 10
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] out,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [OUT_W-1:0] a;
  logic [OUT_W-1:0] b;
  logic [OUT_W-1:0] sum;

  assign sum = a + b;
  assign out = a;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a <= SEED_A;
      b <= SEED_B;
    end else if (last) begin
      a <= SEED_A;
      b <= SEED_B;
    end else begin
      a <= b;
      b <= sum;
    end
  end

  fib_term_counter #(
    .N(N)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .idx (idx),
    .last(last)
  );

endmodule

// File: tb/tb_fibonacci.sv
// Scoreboard bench for fibonacci with N=10 and N=2.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_fibonacci;

  typedef struct {
    int o10;
    int i10;
    int l10;
    int o2;
    int i2;
    int l2;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] out10;
  logic [3:0] idx10;
  logic       last10;
  logic [3:0] out2;
  logic [3:0] idx2;
  logic       last2;

  int   checks = 0;
  int   failures = 0;
  exp_t q[$];
  int   seq10[10] = '{0, 1, 1, 2, 3, 5, 8, 13, 5, 2};
  int   e10;
  int   e2;

  always #5 clk = ~clk;

  fibonacci #(.N(10)) dut (
    .clk (clk),
    .rst (rst),
    .out (out10),
    .idx (idx10),
    .last(last10)
  );

  fibonacci #(.N(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .out (out2),
    .idx (idx2),
    .last(last2)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int a10, input int a2,
                              input bit in_rst);
    exp_t x;
    if (in_rst) begin
      x = '{0, 0, 0, 0, 0, 0};
    end else begin
      x.o10 = seq10[a10];
      x.i10 = a10;
      x.l10 = (a10 == 9) ? 1 : 0;
      x.o2  = a2;
      x.i2  = a2;
      x.l2  = (a2 == 1) ? 1 : 0;
    end
    return x;
  endfunction

  task automatic step_seq();
    q.push_back(mk(e10, e2, 1'b0));
    @(negedge clk);
    #1;
    e10 = (e10 + 1) % 10;
    e2  = e2 ^ 1;
  endtask

  // Monitor: one expectation consumed per falling edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("out10", int'(out10), x.o10);
        chk("idx10", int'(idx10), x.i10);
        chk("last10", int'(last10), x.l10);
        chk("out2", int'(out2), x.o2);
        chk("idx2", int'(idx2), x.i2);
        chk("last2", int'(last2), x.l2);
      end
    end
  end

  initial begin
    int guard;
    q.push_back(mk(0, 0, 1'b1));
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    e10 = 0;
    e2  = 0;
    repeat (31) step_seq();
    while (e10 != 5) step_seq();
    step_seq();
    #1;
    rst = 1'b0;
    #1;
    chk("async_out10", int'(out10), 0);
    chk("async_idx10", int'(idx10), 0);
    chk("async_last10", int'(last10), 0);
    chk("async_out2", int'(out2), 0);
    q.push_back(mk(0, 0, 1'b1));
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    e10 = 0;
    e2  = 0;
    repeat (12) step_seq();
    guard = 0;
    while (q.size() > 0 && guard < 5) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (q.size() > 0) begin
      chk("drain", q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
